// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin grant arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  // Number of requesters served by the arbiter.
  localparam int ARB_N = 4;

  // Pointer reset value: "last granted" = 3, so requester 0 wins first.
  localparam logic [1:0] PTR_RST = 2'd3;

  // Arbiter FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between four requesters and the grant arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; requests are level-sensitive and grants are the only flow control.
//
// Signals:
//   R0..R3 : request lines, driven by the requester side
//   Q0..Q3 : one-hot grant word, driven by the arbiter
//   busy   : high while any grant is active, driven by the arbiter
// Modports:
//   master : requester side (drives R, observes Q/busy)
//   slave  : arbiter side (observes R, drives Q/busy)
interface rr_grant_arbiter_if;
  logic R0, R1, R2, R3;
  logic Q0, Q1, Q2, Q3;
  logic busy;

  modport master (
    output R0, R1, R2, R3,
    input  Q0, Q1, Q2, Q3, busy
  );

  modport slave (
    input  R0, R1, R2, R3,
    output Q0, Q1, Q2, Q3, busy
  );
endinterface : rr_grant_arbiter_if

// File: rtl/rr_grant_arbiter_rr_pick.sv
// Rotating-priority picker: first active request searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   req  [3:0] : request vector
//   ptr  [1:0] : index of the last granted requester
//   pick [3:0] : one-hot winner, all-zero when no request is active
//   idx  [1:0] : index of the winner (equals ptr when no request is active)
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       ptr,
  output logic [ARB_N-1:0] pick,
  output logic [1:0]       idx
);

  always_comb begin
    logic       found;
    logic [1:0] cand;
    pick  = '0;
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    // Offsets 1..4 visit every index exactly once, ending on ptr itself,
    // so the last winner has the lowest priority.
    for (int i = 1; i <= ARB_N; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_grant_arbiter.sv
// Four-requester round-robin arbiter producing a registered one-hot grant word Q3..Q0.
// Latency: request in IDLE at edge k -> grant after edge k; drop at edge k -> clear after k, next grant after k+2.
// Backpressure: the winner holds the grant while requesting; others wait; a zero cycle always separates grants.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : rr_grant_arbiter_if.slave (R0..R3 in, Q0..Q3 and busy out)
// Parameter:
//   HOLD_MAX : maximum grant hold in cycles (1..255), only used with ARB_TIMEOUT_EN
// Build option:
//   ARB_TIMEOUT_EN : when defined, a hold counter forcibly releases a grant after HOLD_MAX cycles.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           rst,
  rr_grant_arbiter_if.slave bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("rr_grant_arbiter: HOLD_MAX must be in 1..255");
  end

  arb_state_e       state;
  logic [1:0]       ptr;
  logic [ARB_N-1:0] q_q;
  logic             busy_q;

  logic [ARB_N-1:0] req;
  logic [ARB_N-1:0] pick;
  logic [1:0]       pick_idx;
  logic             hold_expired;

  assign req = {bus.R3, bus.R2, bus.R1, bus.R0};

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  // The counter holds the number of completed held cycles minus one, so the
  // release decision on cycle HOLD_MAX of the grant sees HOLD_MAX-1.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt;
  assign hold_expired = (hold_cnt == HOLD_LAST);
`else
  assign hold_expired = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RST;
      q_q      <= '0;
      busy_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            q_q      <= pick;
            busy_q   <= 1'b1;
            ptr      <= pick_idx;
            state    <= GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
          end
        end
        GRANT: begin
          // ptr names the current holder; only its request line matters here.
          if (!req[ptr] || hold_expired) begin
            q_q    <= '0;
            busy_q <= 1'b0;
            state  <= RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
`endif
        end
        RELEASE: begin
          // Mandatory all-zero cycle; no arbitration.
          state <= IDLE;
        end
        default: begin
          q_q    <= '0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Q0   = q_q[0];
  assign bus.Q1   = q_q[1];
  assign bus.Q2   = q_q[2];
  assign bus.Q3   = q_q[3];
  assign bus.busy = busy_q;

endmodule : rr_grant_arbiter

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: grant/release timing, rotation, hold, async reset, long hold or timeout.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_rr_grant_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mon_en = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter_if bus ();

  rr_grant_arbiter #(.HOLD_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Observed word: {busy, Q3..Q0}
  function automatic logic [7:0] obs();
    return {3'b000, bus.busy, bus.Q3, bus.Q2, bus.Q1, bus.Q0};
  endfunction

  function automatic logic [7:0] want(input logic [3:0] q);
    return {3'b000, |q, q};
  endfunction

  task automatic set_req(input logic [3:0] r);
    bus.R0 = r[0];
    bus.R1 = r[1];
    bus.R2 = r[2];
    bus.R3 = r[3];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-hot and busy consistency, every cycle away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] q;
      logic       ok;
      q  = {bus.Q3, bus.Q2, bus.Q1, bus.Q0};
      ok = ($countones(q) <= 1) && (bus.busy == |q);
      check("onehot_busy", {7'b0, ok}, 8'h01);
    end
  end

  initial begin
    logic [3:0] r;
    set_req(4'b0000);
    #12;
    check("reset_state", obs(), 8'h00);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();
    check("idle_no_req", obs(), 8'h00);

    // Two requesters; R0 wins from reset pointer, then R2 after release.
    set_req(4'b0101);
    tick();
    check("grant_q0", obs(), want(4'b0001));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_q0", obs(), want(4'b0001));
    end
    set_req(4'b0100);
    tick();
    check("release_0", obs(), 8'h00);
    tick();
    check("release_1", obs(), 8'h00);
    tick();
    check("grant_q2", obs(), want(4'b0100));
    set_req(4'b0000);
    tick();
    tick();

    // Fresh reset, then one-cycle pulses of all four: rotation 0,1,2,3,0.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_req(4'b1111);
      tick();
      set_req(4'b0000);
      check("rotate_grant", obs(), want(4'(1 << (i % 4))));
      tick();
      check("rotate_rel", obs(), 8'h00);
      tick();
      check("rotate_gap", obs(), 8'h00);
    end

    // Grant R1 (pointer now 0), then toggle the other lines.
    set_req(4'b0010);
    tick();
    check("grant_q1", obs(), want(4'b0010));
    for (int i = 0; i < 20; i++) begin
      r = 4'($urandom) | 4'b0010;
      set_req(r);
      tick();
      check("q1_stable", obs(), want(4'b0010));
    end

    // Asynchronous reset between edges while Q1 is held.
    set_req(4'b1001);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", obs(), 8'h00);
    @(negedge clk);
    check("rst_held", obs(), 8'h00);
    rst = 1'b0;
    tick();
    check("post_rst_q0", obs(), want(4'b0001));
    set_req(4'b0000);
    tick();
    tick();

`ifdef ARB_TIMEOUT_EN
    // R2 and R3 both held: R2 evicted after 8 cycles, then R3.
    set_req(4'b1100);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("timeout_hold_q2", obs(), want(4'b0100));
    end
    tick();
    check("timeout_rel", obs(), 8'h00);
    tick();
    check("timeout_gap", obs(), 8'h00);
    tick();
    check("timeout_q3", obs(), want(4'b1000));
`else
    // R2 held for 300 cycles with R3 waiting: no eviction.
    set_req(4'b1100);
    for (int i = 0; i < 300; i++) begin
      tick();
      check("long_hold_q2", obs(), want(4'b0100));
    end
    set_req(4'b1000);
    tick();
    check("long_rel", obs(), 8'h00);
    tick();
    check("long_gap", obs(), 8'h00);
    tick();
    check("long_next_q3", obs(), want(4'b1000));
`endif
    set_req(4'b0000);
    tick();
    tick();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rr_grant_arbiter
